rptr_empty_sync: RTL



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_w2r.sv | 23 ++
 rtl/rptr_empty_sync.sv | 87 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary helpers used by both the read and write stages.
package fifo_pkg;

    localparam int unsigned ADDR_SIZE_DEFAULT = 12;

    // The helpers work for any width up to 32 bits: callers zero-extend the input and
    // size-cast the result back down.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_w2r.sv
// Generic two-flop synchronizer that carries a Gray pointer into the rclk domain.
module sync_w2r #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] rq1;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rq1  <= '0;
            dout <= '0;
        end else begin
            rq1  <= din;
            dout <= rq1;
        end
    end

endmodule

// File: rtl/rptr_empty_sync.sv
// Read-side pointer, empty flag and optional fill level of the async FIFO.
// Define RLEVEL_EN to build the registered rlevel/raempty logic.
module rptr_empty_sync
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE     = ADDR_SIZE_DEFAULT,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rinc,
    input  logic [ADDR_SIZE:0]   rwptr,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE:0]   rq2_wptr,
    output logic                 rempty,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 raempty
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    if (AEMPTY_THRESH > (2 ** ADDR_SIZE)) begin : g_bad_thresh
        $error("AEMPTY_THRESH exceeds FIFO depth");
    end

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic          rempty_val;

    sync_w2r #(
        .WIDTH (PW)
    ) u_sync_w2r (
        .rclk (rclk),
        .rrst (rrst),
        .din  (rwptr),
        .dout (rq2_wptr)
    );

    always_comb begin
        rbinnext   = rbin + PW'(rinc & ~rempty);
        rgraynext  = PW'(bin2gray(32'(rbinnext)));
        rempty_val = (rgraynext == rq2_wptr);
    end

    assign raddr = rbin[ADDR_SIZE-1:0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= rempty_val;
        end
    end

`ifdef RLEVEL_EN
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next;

    // Occupancy is measured against the post-read pointer so it lines up with rempty.
    always_comb begin
        wbin_s     = PW'(gray2bin(32'(rq2_wptr)));
        level_next = wbin_s - rbinnext;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rlevel  <= '0;
            raempty <= 1'b1;
        end else begin
            rlevel  <= level_next;
            raempty <= (level_next <= AE_TH);
        end
    end
`else
    assign rlevel  = '0;
    assign raempty = rempty;
`endif

endmodule
